output_port_arbiter: RTL and testbench

Parametrised router output port: arbitrates flits from N_INPUTS input modules onto one link across N_VC virtual channels. Per-VC round-robin input arbitration with wormhole locking (an input holds a VC until its tail flit is sent), per-VC credit counters for downstream buffer space, selectable VC arbitration mode, and a registered output stage. Sits between the router's input modules and the physical link to the neighbour router or NI.

---
 rtl/ravenoc_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/output_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_output_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared flit field layout and helpers for the router output port.
// Flit: {type[2], x, y, pkt_size, payload}, type in the top bits.
package ravenoc_pkg;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_t;

    localparam int FlitTpWidth = 2;
    localparam int XWidth      = 2;
    localparam int YWidth      = 2;
    localparam int PktWidth    = 8;

    // Index width that stays legal for a single entry.
    function automatic int MinBitWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr.
// Ports: update_i moves ptr past the current winner; req_i/grant_o.
module rr_arbiter
    import ravenoc_pkg::*;
#(
    parameter int N_OF_INPUTS = 2
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   update_i,
    input  logic [N_OF_INPUTS-1:0] req_i,
    output logic [N_OF_INPUTS-1:0] grant_o
);

    localparam int PW = MinBitWidth(N_OF_INPUTS);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;
    int            k;

    always_comb begin
        grant_o = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N_OF_INPUTS; i++) begin
            k = int'(ptr) + i;
            if (k >= N_OF_INPUTS) begin
                k = k - N_OF_INPUTS;
            end
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                ptr_nxt    = (k == N_OF_INPUTS - 1)
                           ? '0 : PW'(k + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ptr <= '0;
        end else if (update_i) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Router output port: per-VC wormhole input arbitration, VC
// arbitration, per-VC credits and a registered link stage.
// Ports: fin_* from input modules, fout_* to link, credit_i in,
// credit_cnt_o / err_credit_o status.
module output_port_arbiter
    import ravenoc_pkg::*;
#(
    parameter  int N_INPUTS       = 4,
    parameter  int N_VC           = 3,
    parameter  int FLIT_WIDTH     = 34,
    parameter  int CREDITS        = 2,
    parameter  int VC_ARB_MODE    = 0,
    parameter  int HIGH_PRIO_ZERO = 1,
    localparam int VC_W           = MinBitWidth(N_VC),
    localparam int CNT_W          = $clog2(CREDITS + 1)
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic [N_INPUTS-1:0]            fin_valid_i,
    input  logic [N_INPUTS*VC_W-1:0]       fin_vc_i,
    input  logic [N_INPUTS*FLIT_WIDTH-1:0] fin_flit_i,
    output logic [N_INPUTS-1:0]            fin_ready_o,
    output logic                           fout_valid_o,
    output logic [VC_W-1:0]                fout_vc_o,
    output logic [FLIT_WIDTH-1:0]          fout_flit_o,
    input  logic [N_VC-1:0]                credit_i,
    output logic [N_VC*CNT_W-1:0]          credit_cnt_o,
    output logic                           err_credit_o
);

    localparam int IN_W   = MinBitWidth(N_INPUTS);
    localparam int TP_HI  = FLIT_WIDTH - 1;
    localparam int PKT_HI = FLIT_WIDTH - FlitTpWidth
                          - XWidth - YWidth - 1;

    logic [N_VC-1:0]       lock;
    logic [IN_W-1:0]       owner [N_VC];
    logic [CNT_W-1:0]      cnt   [N_VC];
    logic [N_INPUTS-1:0]   req   [N_VC];
    logic [N_INPUTS-1:0]   gnt   [N_VC];
    logic [N_VC-1:0]       elig;
    logic [N_VC-1:0]       vc_gnt;
    logic                  accept;
    logic [VC_W-1:0]       sel_vc;
    logic [IN_W-1:0]       win;
    logic [FLIT_WIDTH-1:0] sel_flit;
    flit_type_t            sel_tp;
    logic                  size_nz;
    logic                  pkt_end;

    // Locked VCs only see their owner; elig needs a credit.
    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            req[v] = '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                req[v][i] = fin_valid_i[i]
                    && (fin_vc_i[i*VC_W +: VC_W] == VC_W'(v))
                    && (!lock[v] || owner[v] == IN_W'(i));
            end
            elig[v] = (|req[v]) && (cnt[v] != '0);
        end
    end

    for (genvar v = 0; v < N_VC; v++) begin : g_in_arb
        rr_arbiter #(
            .N_OF_INPUTS(N_INPUTS)
        ) u_in_arb (
            .clk     (clk),
            .arst    (arst),
            .update_i(vc_gnt[v] && pkt_end),
            .req_i   (req[v]),
            .grant_o (gnt[v])
        );
    end

    if (VC_ARB_MODE == 1) begin : g_vc_rr
        rr_arbiter #(
            .N_OF_INPUTS(N_VC)
        ) u_vc_arb (
            .clk     (clk),
            .arst    (arst),
            .update_i(accept),
            .req_i   (elig),
            .grant_o (vc_gnt)
        );
    end else begin : g_vc_fp
        int p;
        // Walk lowest to highest priority; last hit wins.
        always_comb begin
            vc_gnt = '0;
            p      = 0;
            for (int v = 0; v < N_VC; v++) begin
                p = (HIGH_PRIO_ZERO != 0) ? (N_VC - 1 - v) : v;
                if (elig[p]) begin
                    vc_gnt    = '0;
                    vc_gnt[p] = 1'b1;
                end
            end
        end
    end

    assign accept = |vc_gnt;

    always_comb begin
        sel_vc      = '0;
        win         = '0;
        fin_ready_o = '0;
        for (int v = 0; v < N_VC; v++) begin
            if (vc_gnt[v]) begin
                sel_vc      = VC_W'(v);
                fin_ready_o = gnt[v];
            end
        end
        for (int i = 0; i < N_INPUTS; i++) begin
            if (fin_ready_o[i]) begin
                win = IN_W'(i);
            end
        end
    end

    assign sel_flit = fin_flit_i[win*FLIT_WIDTH +: FLIT_WIDTH];
    assign sel_tp   = flit_type_t'(sel_flit[TP_HI -: FlitTpWidth]);
    assign size_nz  = |sel_flit[PKT_HI -: PktWidth];
    assign pkt_end  = (sel_tp == TAIL_FLIT)
                   || (sel_tp == HEAD_FLIT && !size_nz);

    // A head always restarts the packet, even from a locked owner.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            lock <= '0;
            for (int v = 0; v < N_VC; v++) begin
                owner[v] <= '0;
            end
        end else if (accept) begin
            if (sel_tp == HEAD_FLIT) begin
                lock[sel_vc]  <= size_nz;
                owner[sel_vc] <= win;
            end else if (sel_tp == TAIL_FLIT) begin
                lock[sel_vc]  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            err_credit_o <= 1'b0;
            for (int v = 0; v < N_VC; v++) begin
                cnt[v] <= CNT_W'(CREDITS);
            end
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                if (credit_i[v] && !vc_gnt[v]) begin
                    if (cnt[v] == CNT_W'(CREDITS)) begin
                        err_credit_o <= 1'b1;
                    end else begin
                        cnt[v] <= cnt[v] + 1'b1;
                    end
                end else if (!credit_i[v] && vc_gnt[v]) begin
                    cnt[v] <= cnt[v] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        credit_cnt_o = '0;
        for (int v = 0; v < N_VC; v++) begin
            credit_cnt_o[v*CNT_W +: CNT_W] = cnt[v];
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            fout_valid_o <= 1'b0;
            fout_vc_o    <= '0;
            fout_flit_o  <= '0;
        end else begin
            fout_valid_o <= accept;
            if (accept) begin
                fout_vc_o   <= sel_vc;
                fout_flit_o <= sel_flit;
            end
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: two instances,
// fixed-priority (a) and round-robin VC arbitration (b).
module tb_output_port_arbiter;

    logic         clk = 1'b0;
    logic         arst;
    logic [3:0]   va, vb;
    logic [7:0]   vca, vcb;
    logic [135:0] fa, fb;
    logic [2:0]   man_cra, cra, crb;
    logic         ret_a;
    logic [3:0]   rdya, rdyb;
    logic         fva, fvb;
    logic [1:0]   fvca, fvcb;
    logic [33:0]  ffa, ffb;
    logic [5:0]   cnta, cntb;
    logic         erra, errb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign cra = man_cra
               | ((ret_a && fva) ? (3'b001 << fvca) : 3'b000);
    assign crb = fvb ? (3'b001 << fvcb) : 3'b000;

    output_port_arbiter u_dut_a (
        .clk         (clk),
        .arst        (arst),
        .fin_valid_i (va),
        .fin_vc_i    (vca),
        .fin_flit_i  (fa),
        .fin_ready_o (rdya),
        .fout_valid_o(fva),
        .fout_vc_o   (fvca),
        .fout_flit_o (ffa),
        .credit_i    (cra),
        .credit_cnt_o(cnta),
        .err_credit_o(erra)
    );

    output_port_arbiter #(
        .VC_ARB_MODE(1)
    ) u_dut_b (
        .clk         (clk),
        .arst        (arst),
        .fin_valid_i (vb),
        .fin_vc_i    (vcb),
        .fin_flit_i  (fb),
        .fin_ready_o (rdyb),
        .fout_valid_o(fvb),
        .fout_vc_o   (fvcb),
        .fout_flit_o (ffb),
        .credit_i    (crb),
        .credit_cnt_o(cntb),
        .err_credit_o(errb)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic [1:0] tp,
                                       input logic [7:0] sz,
                                       input logic [19:0] pl);
        return {tp, 4'b0000, sz, pl};
    endfunction

    task automatic set_a(input int i, input logic v,
                         input logic [1:0] vc,
                         input logic [33:0] f);
        va[i]          = v;
        vca[i*2 +: 2]  = vc;
        fa[i*34 +: 34] = f;
    endtask

    task automatic set_b(input int i, input logic v,
                         input logic [1:0] vc,
                         input logic [33:0] f);
        vb[i]          = v;
        vcb[i*2 +: 2]  = vc;
        fb[i*34 +: 34] = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [33:0] q0 [3];
    logic [33:0] q2 [3];
    logic [33:0] q1v [4];
    logic [33:0] seq1 [6];
    logic [8:0]  cr_t3;
    logic [8:0]  rd_t3;
    int p0, p2, p;

    initial begin
        arst    = 1'b1;
        va      = '0; vb  = '0;
        vca     = '0; vcb = '0;
        fa      = '0; fb  = '0;
        man_cra = '0;
        ret_a   = 1'b0;
        #2 arst = 1'b0;
        #3;
        chk("rst_valid", 64'(fva), 64'h0);
        chk("rst_vc",    64'(fvca), 64'h0);
        chk("rst_flit",  64'(ffa), 64'h0);
        chk("rst_cnt",   64'(cnta), 64'h2A);
        chk("rst_err",   64'(erra), 64'h0);
        chk("rst_rdy",   64'(rdya), 64'h0);
        repeat (2) @(posedge clk);
        #1 arst = 1'b1;

        // two 3-flit packets on VC0, credits returned by link
        ret_a = 1'b1;
        q0[0] = mk(2'd0, 8'd2, 20'h100);
        q0[1] = mk(2'd1, 8'd0, 20'h101);
        q0[2] = mk(2'd2, 8'd0, 20'h102);
        q2[0] = mk(2'd0, 8'd2, 20'h200);
        q2[1] = mk(2'd1, 8'd0, 20'h201);
        q2[2] = mk(2'd2, 8'd0, 20'h202);
        for (int k = 0; k < 3; k++) begin
            seq1[k]     = q0[k];
            seq1[k + 3] = q2[k];
        end
        p0 = 0; p2 = 0;
        for (int k = 0; k < 6; k++) begin
            set_a(0, p0 < 3, 2'd0, q0[(p0 < 3) ? p0 : 0]);
            set_a(2, p2 < 3, 2'd0, q2[(p2 < 3) ? p2 : 0]);
            @(negedge clk);
            chk("t1_rdy", 64'(rdya),
                (k < 3) ? 64'h1 : 64'h4);
            if (rdya[0]) p0++;
            if (rdya[2]) p2++;
            tick();
            chk("t1_flit", 64'(ffa), 64'(seq1[k]));
            chk("t1_vc",   64'(fvca), 64'h0);
        end
        set_a(0, 1'b0, 2'd0, '0);
        set_a(2, 1'b0, 2'd0, '0);
        tick();
        ret_a = 1'b0;
        tick();
        chk("t1_cnt", 64'(cnta), 64'h2A);

        // single-flit heads on VC2 and VC0, VC0 wins
        set_a(1, 1'b1, 2'd2, mk(2'd0, 8'd0, 20'h11));
        set_a(3, 1'b1, 2'd0, mk(2'd0, 8'd0, 20'h33));
        @(negedge clk);
        chk("t2_rdy0", 64'(rdya), 64'h8);
        tick();
        chk("t2_vc0",   64'(fvca), 64'h0);
        chk("t2_flit0", 64'(ffa), 64'(mk(2'd0, 8'd0, 20'h33)));
        set_a(3, 1'b0, 2'd0, '0);
        @(negedge clk);
        chk("t2_rdy1", 64'(rdya), 64'h2);
        tick();
        chk("t2_vc1",   64'(fvca), 64'h2);
        chk("t2_flit1", 64'(ffa), 64'(mk(2'd0, 8'd0, 20'h11)));
        chk("t2_val",   64'(fva), 64'h1);
        set_a(1, 1'b0, 2'd0, '0);
        tick();
        chk("t2_noval", 64'(fva), 64'h0);
        chk("t2_cnt",   64'(cnta), 64'h19);

        // credit starvation on VC1
        q1v[0] = mk(2'd0, 8'd3, 20'h300);
        q1v[1] = mk(2'd1, 8'd0, 20'h301);
        q1v[2] = mk(2'd1, 8'd0, 20'h302);
        q1v[3] = mk(2'd2, 8'd0, 20'h303);
        cr_t3 = 9'b0_1001_0000;
        rd_t3 = 9'b1_0010_0011;
        p = 0;
        for (int k = 0; k < 9; k++) begin
            set_a(0, p < 4, 2'd1, q1v[(p < 4) ? p : 0]);
            man_cra = {1'b0, cr_t3[k], 1'b0};
            @(negedge clk);
            chk("t3_rdy", 64'(rdya), 64'(rd_t3[k]));
            if (k == 3) chk("t3_cnt0", 64'(cnta), 64'h11);
            if (rdya[0]) p++;
            tick();
        end
        chk("t3_tail", 64'(ffa), 64'(q1v[3]));
        set_a(0, 1'b0, 2'd0, '0);
        man_cra = 3'b010;
        tick();
        tick();
        man_cra = 3'b000;
        chk("t3_cnt", 64'(cnta), 64'h19);

        // send and credit together, then overflow
        set_a(2, 1'b1, 2'd0, mk(2'd0, 8'd0, 20'h22));
        man_cra = 3'b001;
        @(negedge clk);
        chk("t4_rdy", 64'(rdya), 64'h4);
        tick();
        set_a(2, 1'b0, 2'd0, '0);
        chk("t4_cnt_same", 64'(cnta), 64'h19);
        tick();
        chk("t4_cnt_full", 64'(cnta), 64'h1A);
        chk("t4_err0", 64'(erra), 64'h0);
        tick();
        man_cra = 3'b000;
        chk("t4_err1", 64'(erra), 64'h1);
        chk("t4_cnt_ovf", 64'(cnta), 64'h1A);
        tick();
        chk("t4_err_stk", 64'(erra), 64'h1);
        man_cra = 3'b100;
        tick();
        man_cra = 3'b000;
        chk("t4_cnt_rst", 64'(cnta), 64'h2A);

        // reset in the middle of a locked packet
        set_a(1, 1'b1, 2'd0, mk(2'd0, 8'd2, 20'h44));
        @(negedge clk);
        chk("t6_rdy_h", 64'(rdya), 64'h2);
        tick();
        set_a(1, 1'b0, 2'd0, '0);
        set_a(3, 1'b1, 2'd0, mk(2'd1, 8'd0, 20'h55));
        @(negedge clk);
        chk("t6_locked", 64'(rdya), 64'h0);
        chk("t6_val_pre", 64'(fva), 64'h1);
        #2 arst = 1'b0;
        #1;
        chk("t6_val_rst", 64'(fva), 64'h0);
        chk("t6_cnt_rst", 64'(cnta), 64'h2A);
        chk("t6_err_rst", 64'(erra), 64'h0);
        #1 arst = 1'b1;
        #1;
        chk("t6_unlock", 64'(rdya), 64'h8);
        tick();
        chk("t6_flit", 64'(ffa), 64'(mk(2'd1, 8'd0, 20'h55)));
        set_a(3, 1'b0, 2'd0, '0);
        tick();

        // round-robin VC arbitration on instance b
        set_b(0, 1'b1, 2'd0, mk(2'd1, 8'd0, 20'hB0));
        set_b(1, 1'b1, 2'd1, mk(2'd1, 8'd0, 20'hB1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_rdy", 64'(rdyb),
                k[0] ? 64'h2 : 64'h1);
            tick();
            chk("t5_vc", 64'(fvcb), 64'(k[0]));
            chk("t5_flit", 64'(ffb), k[0]
                ? 64'(mk(2'd1, 8'd0, 20'hB1))
                : 64'(mk(2'd1, 8'd0, 20'hB0)));
        end
        set_b(0, 1'b0, 2'd0, '0);
        set_b(1, 1'b0, 2'd0, '0);
        tick();
        tick();
        chk("t5_cnt", 64'(cntb), 64'h2A);
        chk("t5_err", 64'(errb), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
